// File: rtl/bus_sequencer.sv
// Fetch/execute microstep controller: drives the datapath bus select code and register load strobes.
// Optional macro SEQ_TIMEOUT_EN adds a T1 memory-wait timeout that aborts to IDLE and raises error.
module bus_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op_class,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [4:0]  bus_sel,
    output logic        pc_in,
    output logic        mar_in,
    output logic        inc_pc,
    output logic        z_in,
    output logic        y_in,
    output logic        ir_in,
    output logic        mdr_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic        mem_read,
    output logic        alu_go,
    output logic [15:0] reg_in,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

    localparam logic [4:0] SEL_ZHI = 5'd18;
    localparam logic [4:0] SEL_ZLO = 5'd19;
    localparam logic [4:0] SEL_PC  = 5'd20;
    localparam logic [4:0] SEL_MDR = 5'd21;
    localparam logic [4:0] SEL_CSE = 5'd23;

    state_t      state, next_state;
    logic [1:0]  cls_q;
    logic        timeout_hit;
    logic [3:0]  ra, rb, rc;
    logic        unused_ir_bits;

    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];
    assign unused_ir_bits = ^{ir[31:27], ir[14:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // The class is captured on leaving T2 so the execute steps ignore later decoder changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         cls_q <= 2'd0;
        else if (state == T2) cls_q <= op_class;
    end

`ifdef SEQ_TIMEOUT_EN
    logic [TO_W-1:0] wait_cnt;
    logic            error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       wait_cnt <= '0;
        else if (state == T0)               wait_cnt <= '0;
        else if (state == T1 && !mem_ready) wait_cnt <= wait_cnt + TO_W'(1);
    end

    assign timeout_hit = (state == T1) && !mem_ready && (wait_cnt == TO_W'(MEM_TIMEOUT - 1));

    // Sticky until the next accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   error_q <= 1'b0;
        else if (state == IDLE && start) error_q <= 1'b0;
        else if (timeout_hit)           error_q <= 1'b1;
    end

    assign error = error_q;
`else
    localparam int unused_timeout_cfg = MEM_TIMEOUT + TO_W;
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_comb begin
        next_state = state;
        bus_sel    = 5'd0;
        pc_in      = 1'b0;
        mar_in     = 1'b0;
        inc_pc     = 1'b0;
        z_in       = 1'b0;
        y_in       = 1'b0;
        ir_in      = 1'b0;
        mdr_in     = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        mem_read   = 1'b0;
        alu_go     = 1'b0;
        reg_in     = 16'd0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = T0;
            end
            T0: begin
                bus_sel    = SEL_PC;
                mar_in     = 1'b1;
                inc_pc     = 1'b1;
                z_in       = 1'b1;
                next_state = T1;
            end
            T1: begin
                bus_sel  = SEL_ZLO;
                pc_in    = 1'b1;
                mem_read = 1'b1;
                if (timeout_hit) begin
                    next_state = IDLE;
                end else if (mem_ready) begin
                    mdr_in     = 1'b1;
                    next_state = T2;
                end
            end
            T2: begin
                bus_sel = SEL_MDR;
                ir_in   = 1'b1;
                if (op_class == 2'd3) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = T3;
                end
            end
            T3: begin
                bus_sel    = {1'b0, rb};
                y_in       = 1'b1;
                next_state = T4;
            end
            T4: begin
                bus_sel    = (cls_q == 2'd1) ? SEL_CSE : {1'b0, rc};
                alu_go     = 1'b1;
                z_in       = 1'b1;
                next_state = T5;
            end
            T5: begin
                bus_sel = SEL_ZLO;
                if (cls_q == 2'd2) begin
                    lo_in      = 1'b1;
                    next_state = T6;
                end else begin
                    reg_in     = 16'd1 << ra;
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            T6: begin
                bus_sel    = SEL_ZHI;
                hi_in      = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: expected per-cycle output traces are built from the
// instruction class, IR fields and memory wait count, then compared cycle by cycle.
module tb_bus_sequencer;
    localparam int MEM_TIMEOUT = 15;

    localparam logic [10:0] PC_IN  = 11'h400;
    localparam logic [10:0] MAR_IN = 11'h200;
    localparam logic [10:0] INC_PC = 11'h100;
    localparam logic [10:0] Z_IN   = 11'h080;
    localparam logic [10:0] Y_IN   = 11'h040;
    localparam logic [10:0] IR_IN  = 11'h020;
    localparam logic [10:0] MDR_IN = 11'h010;
    localparam logic [10:0] HI_IN  = 11'h008;
    localparam logic [10:0] LO_IN  = 11'h004;
    localparam logic [10:0] MEM_RD = 11'h002;
    localparam logic [10:0] ALU_GO = 11'h001;

    typedef struct packed {
        logic [4:0]  sel;
        logic [10:0] strb;
        logic [15:0] regs;
        logic        fin;
    } step_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op_class;
    logic [31:0] ir;
    logic        mem_ready;
    logic [4:0]  bus_sel;
    logic        pc_in, mar_in, inc_pc, z_in, y_in, ir_in, mdr_in, hi_in, lo_in;
    logic        mem_read, alu_go;
    logic [15:0] reg_in;
    logic        busy, done, error;
    logic [10:0] strobes_obs;

    int    checks = 0;
    int    errors = 0;
    logic  err_exp = 1'b0;
    step_t q[$];

    assign strobes_obs = {pc_in, mar_in, inc_pc, z_in, y_in, ir_in, mdr_in, hi_in, lo_in, mem_read, alu_go};

    always #5 clk = ~clk;

    bus_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_class(op_class), .ir(ir),
        .mem_ready(mem_ready), .bus_sel(bus_sel), .pc_in(pc_in), .mar_in(mar_in),
        .inc_pc(inc_pc), .z_in(z_in), .y_in(y_in), .ir_in(ir_in), .mdr_in(mdr_in),
        .hi_in(hi_in), .lo_in(lo_in), .mem_read(mem_read), .alu_go(alu_go),
        .reg_in(reg_in), .busy(busy), .done(done), .error(error)
    );

    function automatic step_t mk(input logic [4:0] sel, input logic [10:0] strb,
                                 input logic [15:0] regs, input logic fin);
        step_t s;
        s.sel = sel; s.strb = strb; s.regs = regs; s.fin = fin;
        return s;
    endfunction

    function automatic logic [31:0] ir_of(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
        logic [31:0] r;
        r = $urandom;
        r[26:23] = ra; r[22:19] = rb; r[18:15] = rc;
        return r;
    endfunction

    // Expected busy-period trace of one instruction: T0, waits, ready T1, T2, then class-dependent execute.
    task automatic build_trace(input int cls, input logic [31:0] ir_word, input int waits, input bit abort);
        logic [3:0] ra, rb, rc;
        ra = ir_word[26:23]; rb = ir_word[22:19]; rc = ir_word[18:15];
        q.delete();
        q.push_back(mk(5'd20, MAR_IN | INC_PC | Z_IN, 16'd0, 1'b0));
        for (int i = 0; i < waits; i++) q.push_back(mk(5'd19, PC_IN | MEM_RD, 16'd0, 1'b0));
        if (abort) return;
        q.push_back(mk(5'd19, PC_IN | MEM_RD | MDR_IN, 16'd0, 1'b0));
        q.push_back(mk(5'd21, IR_IN, 16'd0, logic'(cls == 3)));
        if (cls == 3) return;
        q.push_back(mk({1'b0, rb}, Y_IN, 16'd0, 1'b0));
        q.push_back(mk((cls == 1) ? 5'd23 : {1'b0, rc}, ALU_GO | Z_IN, 16'd0, 1'b0));
        if (cls == 2) begin
            q.push_back(mk(5'd19, LO_IN, 16'd0, 1'b0));
            q.push_back(mk(5'd18, HI_IN, 16'd0, 1'b1));
        end else begin
            q.push_back(mk(5'd19, 11'd0, 16'd1 << ra, 1'b1));
        end
    endtask

    task automatic check_output(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s step %0d observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    task automatic check_step(input step_t e, input int idx);
        check_output("bus_sel", idx, 32'(bus_sel), 32'(e.sel));
        check_output("strobes", idx, 32'(strobes_obs), 32'(e.strb));
        check_output("reg_in", idx, 32'(reg_in), 32'(e.regs));
        check_output("done", idx, 32'(done), 32'(e.fin));
        check_output("busy", idx, 32'(busy), 32'd1);
        check_output("error", idx, 32'(error), 32'(err_exp));
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_bus_sel"}, -1, 32'(bus_sel), 32'd0);
        check_output({tag, "_strobes"}, -1, 32'(strobes_obs), 32'd0);
        check_output({tag, "_reg_in"}, -1, 32'(reg_in), 32'd0);
        check_output({tag, "_busy"}, -1, 32'(busy), 32'd0);
        check_output({tag, "_done"}, -1, 32'(done), 32'd0);
        check_output({tag, "_error"}, -1, 32'(error), 32'(err_exp));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        start = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        #1 check_idle("idle");
    endtask

    // Issues one instruction from IDLE; stop_at >= 0 returns early with the DUT left in that step's predecessor.
    task automatic apply_stimulus(input int cls, input logic [31:0] ir_word, input int waits,
                                  input bit abort, input int stop_at);
        build_trace(cls, ir_word, waits, abort);
        @(negedge clk);
        start = 1'b1;
        op_class = 2'(cls);
        ir = ir_word;
        mem_ready = 1'($urandom_range(0, 1));
        #1 check_idle("pre_start");
        err_exp = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (i == stop_at) return;
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            op_class = (i <= waits + 2) ? 2'(cls) : 2'($urandom_range(0, 3));
            if (i >= 1 && i <= waits)            mem_ready = 1'b0;
            else if (i == waits + 1 && !abort)   mem_ready = 1'b1;
            else                                 mem_ready = 1'($urandom_range(0, 1));
            #1 check_step(q[i], i);
        end
        if (abort) err_exp = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        start = 1'b0;
        op_class = 2'd0;
        ir = 32'd0;
        mem_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_idle("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        apply_stimulus(0, ir_of(4'd3, 4'd5, 4'd7), 0, 1'b0, -1);
        apply_stimulus(1, ir_of(4'd15, 4'd2, 4'($urandom)), 0, 1'b0, -1);
        apply_stimulus(2, ir_of(4'($urandom), 4'($urandom), 4'($urandom)), 0, 1'b0, -1);
        apply_stimulus(3, $urandom, 0, 1'b0, -1);
        apply_stimulus(0, ir_of(4'd0, 4'd9, 4'd12), 3, 1'b0, -1);
        idle_cycle();

        // Reset asserted mid-T4 must clear every output in the same cycle.
        apply_stimulus(0, ir_of(4'd6, 4'd1, 4'd2), 0, 1'b0, 5);
        reset_n = 1'b0;
        err_exp = 1'b0;
        #1 check_idle("mid_reset");
        @(negedge clk);
        start = 1'b0;
        #1 check_idle("held_reset");
        reset_n = 1'b1;
        idle_cycle();

`ifdef SEQ_TIMEOUT_EN
        apply_stimulus(0, $urandom, MEM_TIMEOUT, 1'b1, -1);
        idle_cycle();
        idle_cycle();
        apply_stimulus(1, $urandom, 1, 1'b0, -1);
`else
        apply_stimulus(0, $urandom, MEM_TIMEOUT + 5, 1'b0, -1);
`endif

        for (int n = 0; n < 30; n++) begin
            apply_stimulus($urandom_range(0, 3), $urandom, $urandom_range(0, 4), 1'b0, -1);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
